// File: rtl/gb_pkg.sv
// Shared types and constants for the OAM DMA engine.
package gb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RD,
        LATCH,
        WR,
        GAP
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int          OAM_SIZE     = 160;
    localparam logic [7:0]  ECHO_MASK    = 8'hDF;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies one 160-byte source page into OAM,
// one byte per four CPU clocks, after a write to FF46.
module oam_dma
    import gb_pkg::*;
#(
    parameter int OAM_BYTES   = OAM_SIZE,
    parameter int START_DELAY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reg_wren,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_rden,
    input  logic [7:0]  bus_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_wren,
    input  logic        oam_busy,
    output logic        active,
    output logic        done
);

    localparam logic [1:0] DLY_LAST = 2'(START_DELAY - 1);
    localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);

    dma_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic [7:0] src_eff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        src_d   = src_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: ;
            START: begin
                if (cnt_q == DLY_LAST) begin
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RD: state_d = LATCH;
            LATCH: begin
                data_d  = bus_data;
                state_d = WR;
            end
            WR: begin
                if (!oam_busy) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
        // A register write always (re)starts, even over the final GAP.
        if (reg_wren) begin
            src_d   = reg_wdata;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = START;
            done_d  = 1'b0;
        end
    end

    assign src_eff   = (src_q >= 8'hE0) ? (src_q & ECHO_MASK) : src_q;
    assign reg_rdata = src_q;
    assign bus_addr  = {src_eff, idx_q};
    assign bus_rden  = (state_q == RD);
    assign oam_addr  = idx_q;
    assign oam_wdata = data_q;
    assign oam_wren  = (state_q == WR) && !oam_busy;
    assign active    = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma.
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wren = 1'b0;
    logic [7:0]  reg_wdata = 8'h00;
    logic [7:0]  reg_rdata;
    logic [15:0] bus_addr;
    logic        bus_rden;
    logic [7:0]  bus_data = 8'h00;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_wren;
    logic        oam_busy = 1'b0;
    logic        active;
    logic        done;

    oam_dma dut (
        .clock     (clock),
        .reset     (reset),
        .reg_wren  (reg_wren),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .bus_addr  (bus_addr),
        .bus_rden  (bus_rden),
        .bus_data  (bus_data),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_wren  (oam_wren),
        .oam_busy  (oam_busy),
        .active    (active),
        .done      (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    logic use_hi = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Source memory: byte appears the cycle after the read strobe.
    always @(posedge clock)
        bus_data <= bus_rden ?
            (bus_addr[7:0] ^ (use_hi ? bus_addr[15:8] : 8'h5A)) : 8'h00;

    int          n_wr = 0;
    int          wr_rel  [0:2047];
    logic [7:0]  wr_addr [0:2047];
    logic [7:0]  wr_data [0:2047];
    int          n_rd = 0;
    int          rd_rel  [0:2047];
    logic [15:0] rd_addr [0:2047];
    int          n_done = 0;
    int          done_rel = -1;
    int          fall_rel = -1;
    int          range_bad = 0;
    logic        prev_act = 1'b0;

    always @(negedge clock) begin : mon
        int r;
        r = cyc - base + 1;
        if (oam_wren) begin
            if (oam_addr >= 8'd160) range_bad <= range_bad + 1;
            wr_rel[n_wr]  <= r;
            wr_addr[n_wr] <= oam_addr;
            wr_data[n_wr] <= oam_wdata;
            n_wr <= n_wr + 1;
        end
        if (bus_rden) begin
            rd_rel[n_rd]  <= r;
            rd_addr[n_rd] <= bus_addr;
            n_rd <= n_rd + 1;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_rel <= r;
        end
        if (prev_act && !active) fall_rel <= r;
        prev_act <= active;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] v);
        reg_wren  = 1'b1;
        reg_wdata = v;
        step();
        base     = cyc;
        reg_wren = 1'b0;
    endtask

    task automatic goto_cycle(input int n);
        for (int k = 0; k < 5000 && (cyc - base + 1) < n; k++) step();
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int k = 0; k < 1000 && n_done <= d0; k++) step();
        chk(tag, 32'(n_done > d0), 32'd1);
        step();
    endtask

    // Mismatches over 160 unstalled writes starting at log index w0.
    function automatic int seq_bad(input int w0, input logic [7:0] key);
        int bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (wr_addr[w0+i] !== 8'(i)) bad++;
            if (wr_data[w0+i] !== (8'(i) ^ key)) bad++;
            if (wr_rel[w0+i] != 7 + 4*i) bad++;
        end
        return bad;
    endfunction

    initial begin
        int w0, r0, d0, bad;

        #2;
        chk("rst_active", active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wren", oam_wren, 1'b0);
        chk("rst_rden", bus_rden, 1'b0);
        chk("rst_rdata", reg_rdata, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        step();

        // Basic copy from C1xx.
        w0 = n_wr; d0 = n_done;
        write_reg(8'hC1);
        chk("basic_active_c1", active, 1'b1);
        wait_done("basic_timeout", d0);
        chk("basic_nwr", n_wr - w0, 160);
        chk("basic_seq_bad", seq_bad(w0, 8'h5A), 0);
        chk("basic_last_rel", wr_rel[w0+159], 643);
        chk("basic_done_rel", done_rel, 645);
        chk("basic_fall_rel", fall_rel, 645);
        chk("basic_ndone", n_done - d0, 1);
        chk("basic_rdata", reg_rdata, 8'hC1);

        // Echo page E3 maps to C3.
        w0 = n_wr; r0 = n_rd; d0 = n_done;
        write_reg(8'hE3);
        wait_done("echo_timeout", d0);
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (rd_addr[r0+i] !== 16'hC300 + 16'(i)) bad++;
        chk("echo_nrd", n_rd - r0, 160);
        chk("echo_addr_bad", bad, 0);
        chk("echo_last_addr", rd_addr[r0+159], 16'hC39F);
        chk("echo_rdata", reg_rdata, 8'hE3);
        chk("echo_seq_bad", seq_bad(w0, 8'h5A), 0);

        // PPU holds OAM for three cycles during byte 10's WR.
        w0 = n_wr; d0 = n_done;
        write_reg(8'hC1);
        goto_cycle(47);
        oam_busy = 1'b1;
        goto_cycle(50);
        oam_busy = 1'b0;
        wait_done("busy_timeout", d0);
        chk("busy_nwr", n_wr - w0, 160);
        chk("busy_b9_rel", wr_rel[w0+9], 43);
        chk("busy_b10_rel", wr_rel[w0+10], 50);
        chk("busy_b10_addr", wr_addr[w0+10], 8'd10);
        chk("busy_b10_data", wr_data[w0+10], 8'd10 ^ 8'h5A);
        chk("busy_b11_rel", wr_rel[w0+11], 54);
        chk("busy_done_rel", done_rel, 648);

        // Restart from C0 to D0 at cycle 100.
        use_hi = 1'b1;
        w0 = n_wr; d0 = n_done;
        write_reg(8'hC0);
        goto_cycle(100);
        write_reg(8'hD0);
        chk("rst_pre_nwr", n_wr - w0, 24);
        w0 = n_wr; r0 = n_rd;
        wait_done("restart_timeout", d0);
        chk("restart_rd_rel", rd_rel[r0], 5);
        chk("restart_rd_addr", rd_addr[r0], 16'hD000);
        chk("restart_nwr", n_wr - w0, 160);
        chk("restart_seq_bad", seq_bad(w0, 8'hD0), 0);
        chk("restart_ndone", n_done - d0, 1);
        use_hi = 1'b0;

        // Asynchronous reset in the middle of byte 80's LATCH.
        w0 = n_wr; d0 = n_done;
        write_reg(8'hC2);
        goto_cycle(326);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_active", active, 1'b0);
        chk("areset_done", done, 1'b0);
        chk("areset_wren", oam_wren, 1'b0);
        chk("areset_rden", bus_rden, 1'b0);
        chk("areset_busaddr", bus_addr, 16'h0000);
        chk("areset_oamaddr", oam_addr, 8'h00);
        chk("areset_wdata", oam_wdata, 8'h00);
        chk("areset_rdata", reg_rdata, 8'h00);
        chk("areset_pre_nwr", n_wr - w0, 80);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        step();
        repeat (40) step();
        chk("areset_post_nwr", n_wr - w0, 80);
        chk("areset_ndone", n_done - d0, 0);
        w0 = n_wr;
        write_reg(8'hC4);
        wait_done("areset_new_timeout", d0);
        chk("areset_new_nwr", n_wr - w0, 160);
        chk("areset_new_seq_bad", seq_bad(w0, 8'h5A), 0);

        // Register write lands on the final GAP: restart, no done.
        w0 = n_wr; d0 = n_done;
        write_reg(8'hC5);
        goto_cycle(644);
        write_reg(8'hC6);
        chk("gap_pre_nwr", n_wr - w0, 160);
        chk("gap_no_done", n_done - d0, 0);
        chk("gap_active", active, 1'b1);
        w0 = n_wr;
        wait_done("gap_timeout", d0);
        chk("gap_done_rel", done_rel, 645);
        chk("gap_ndone", n_done - d0, 1);
        chk("gap_seq_bad", seq_bad(w0, 8'h5A), 0);
        chk("idx_range_bad", range_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine: the writer side of object attribute memory, feeding the 160-byte OAM that the ppu reads during sprite search. A CPU write to register FF46 (decoded by the memory map) latches a source page. The engine then copies 160 bytes from {page, 8'h00} into OAM at one byte per 4 CPU clocks. It holds `active` so the memory map can block conflicting CPU bus accesses. It sits between the memory map's read port and the OAM write port, on the CPU `clock` domain.

## Interface
Parameters:
- OAM_BYTES, 160, bytes per transfer; the final index is OAM_BYTES-1.
- START_DELAY, 4, idle cycles between the register write and the first source read.

Ports:
- clock  in  1  CPU clock; the only clock.
- reset  in  1  asynchronous, active-high.
- reg_wren  in  1  CPU write strobe for FF46, already address-decoded.
- reg_wdata  in  8  source page high byte.
- reg_rdata  out  8  last value written to FF46 (raw, unmasked).
- bus_addr  out  16  source read address.
- bus_rden  out  1  source read strobe.
- bus_data  in  8  source byte; valid in the cycle after `bus_rden`.
- oam_addr  out  8  OAM write index, 0..159.
- oam_wdata  out  8  byte to write.
- oam_wren  out  1  OAM write strobe.
- oam_busy  in  1  the ppu owns OAM this cycle; the write must wait.
- active  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the transfer completes.

## Operation
- States: IDLE, START, RD, LATCH, WR, GAP.
- IDLE: all strobes low. `reg_wren` latches `reg_wdata` into src_q and reg_rdata, clears idx and the delay counter, and moves to START.
- START: stays START_DELAY cycles, then moves to RD.
- RD: `bus_rden`=1 and `bus_addr`={src_eff, idx}. Next state is LATCH.
- Source mapping: src_eff = src_q & 8'hDF when src_q >= 8'hE0 (echo mapping to C0–DF); otherwise src_eff = src_q.
- LATCH: captures `bus_data` into data_q, then moves to WR.
- WR: `oam_wren` = ~oam_busy, with `oam_addr`=idx and `oam_wdata`=data_q.
  - While `oam_busy` is high, stay in WR with no write and data_q held.
  - Otherwise move to GAP.
- GAP: no strobes.
  - If idx == OAM_BYTES-1: go to IDLE and assert `done` in the following cycle.
  - Else: idx += 1 and go to RD.
- `active` = (state != IDLE).
- idx is 8 bits and never wraps; it exceeds 159 only through a spec violation, which the bench asserts never happens.
- Restart: `reg_wren` while active aborts the current transfer.
  - src_q is reloaded, idx and the delay counter are cleared, and the next state is START.
  - A WR strobe already asserted in the restart cycle still completes.
  - The byte held in LATCH is discarded.
- `reg_wren` in the same cycle as the final GAP: restart wins; `done` does not pulse.
- Reset, asynchronous and at any point including mid-transfer:
  - state=IDLE; idx, src_q, data_q, reg_rdata all 0.
  - All strobes, `active` and `done` are 0.
  - No further OAM writes occur.

## Timing
- Cycle n counts from the edge that samples `reg_wren` (n=1 is the first cycle after it).
- START occupies cycles 1–4.
- Byte i, with no stall:
  - RD at cycle 5+4i; data sampled at the end of cycle 6+4i.
  - WR at cycle 7+4i; GAP at cycle 8+4i.
- `active` is high in cycles 1–644, low from cycle 645.
- `done` is high in cycle 645 only.
- Each `oam_busy` cycle during WR delays every later event by exactly one cycle.
- Outputs are decoded from registered state only; `oam_wren` alone also depends combinationally on `oam_busy`.

## Structure
- Shared package `gb_pkg` holds:
  - typedef enum `dma_state_t` {IDLE, START, RD, LATCH, WR, GAP}.
  - constants `DMA_REG_ADDR`=16'hFF46, `OAM_SIZE`=160, `ECHO_MASK`=8'hDF.
- Single module, no sub-module. Its registers are the state, a 2-bit delay counter, idx, src_q, data_q and done_q.

## Test plan
- Basic copy: write 8'hC1, source returns addr[7:0]^8'h5A.
  - -> 160 OAM writes; write i lands at cycle 7+4i with addr=i and data=i^8'h5A.
  - -> `active` falls at cycle 645; `done` pulses once.
- Echo source: write 8'hE3.
  - -> `bus_addr` runs 16'hC300..16'hC39F; `reg_rdata` reads 8'hE3.
- PPU contention: hold `oam_busy` for 3 cycles during byte 10's WR.
  - -> byte 10 written at cycle 50 with correct data.
  - -> `done` pulses at cycle 648.
- Restart: write 8'hC0, then write 8'hD0 at cycle 100.
  - -> the next RD (cycle 105) is at 16'hD000.
  - -> 160 subsequent writes come from D0xx.
- Reset at byte 80: assert `reset` asynchronously mid-LATCH.
  - -> all outputs 0 immediately; no further `oam_wren`.
  - -> a new write after release starts cleanly from idx 0.
